// File: rtl/uart_tx_frame.sv
// UART transmitter: one-entry holding register feeding a start/data/parity/stop
// shift FSM. LSB first, idle-high line, back-to-back frames with no idle gap.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   tx_data     - word to send, captured when tx_valid && tx_ready
//   tx_valid    - tx_data is valid
//   tx_ready    - holding register empty
//   tx          - serial line (idle high)
//   busy        - a frame is on the line (start through last stop)
//   frame_done  - one-cycle pulse in the final cycle of the last stop bit
module uart_tx_frame #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = 4;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              HAS_PAR   = (PARITY != 0);
  localparam logic              ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [DATA_BITS-1:0]  hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;
  logic                  baud_end;
  logic                  load;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  // Next state, holding register, and next values of the registered outputs
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    par_d       = par_q;
    done_d      = 1'b0;
    load        = 1'b0;
    tx_d        = 1'b1;
    baud_end    = (baud_q == BAUD_LAST);

    if (state_q != S_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) load = 1'b1;
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        // Raised one cycle early so the registered pulse lands on the last cycle
        if (bit_q == STOP_LAST && baud_q == BAUD_PRE) done_d = 1'b1;
        if (baud_end) begin
          if (bit_q == STOP_LAST) begin
            if (hold_full_q) load = 1'b1;
            else             state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Drain the holding register; parity is taken from the whole captured word
    if (load) begin
      state_d     = S_START;
      bit_d       = '0;
      shift_d     = hold_q;
      par_d       = (^hold_q) ^ ODD_PAR;
      hold_full_d = 1'b0;
    end

    // Accept only when empty, so it never coincides with a drain
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = !hold_full_d;
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign tx_ready   = ready_q;

endmodule
